cpu_ctrl_fsm: RTL and testbench

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm
Interface
REQ-001 Parameter MEM_TO, default 16: mem_ack wait cycles before trap (1..2^MEM_TO_W-1).
REQ-002 Parameter MEM_TO_W, default 8: wait-counter width.
REQ-003 One clock; reset synchronous, active-high.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ir  in  32  instruction word, decoded in FETCH/DECODE.
REQ-007 ir_valid  in  1  ir and cond_pass valid this cycle.
REQ-008 dp_ctrl_i  in  DP_W  decoded {S,ALU_OP,SHIFT_OP,RS_IMM_S,RM_IMM_S}.
REQ-009 ttcc  in  1  test/compare op; no register writeback.
REQ-010 cond_pass  in  1  condition field satisfied by current flags.
REQ-011 mem_ack  in  1  data memory completes access.
REQ-012 write_pc, write_ir, write_reg  out  1 each  register write strobes.
REQ-013 ld_abc  out  3  load A/B/C operand latches.
REQ-014 lf  out  1  load F result/flags.
REQ-015 pc_s  out  2  PC source: 00 PC+4, 01 B latch, 10 F.
REQ-016 alu_a_s, alu_b_s, rd_s, wb_s  out  1 each  ALU-A=PC, ALU-B=ext(imm24), rd=R14, writeback=MDR.
REQ-017 dp_ctrl  out  DP_W  datapath control to shifter/ALU.
REQ-018 mem_req, mem_we, trap  out  1 each  memory request, store, sticky timeout error.
Function
REQ-019 Moore: outputs decoded from state register; unlisted outputs 0; dp_ctrl 0 except EXEC, BCALC, BLLINK, BLCALC, MADDR.
REQ-020 Decode: isB ir[27:24]=1010; isBL 1011; isBX ir[27:4]=0x12FFF1; isLDST ir[27:26]=01; load=ir[20]; up=ir[23].
REQ-021 IDLE -> FETCH unconditionally.
REQ-022 FETCH: write_pc=write_ir=ir_valid, pc_s=00; hold while !ir_valid; on ir_valid: !cond_pass->FETCH, isB->BCALC, isBL->BLLINK, else DECODE.
REQ-023 DECODE: ld_abc=111; isBX->BX; isLDST->MADDR; else EXEC.
REQ-024 EXEC: lf=1, dp_ctrl=dp_ctrl_i; ttcc->FETCH else WB. WB: write_reg=1, wb_s=0 -> FETCH.
REQ-025 BX: write_pc=1, pc_s=01 -> FETCH. BCALC: alu_a_s=alu_b_s=lf=1, ALU_OP=0100, S=0 -> BPC. BPC: write_pc=1, pc_s=10 -> FETCH.
REQ-026 BLLINK: alu_a_s=lf=1, ALU_OP=1000, S=0 -> BLCALC. BLCALC: BCALC outputs plus rd_s=write_reg=1 -> BPC.
REQ-027 MADDR: lf=1, dp_ctrl=dp_ctrl_i with ALU_OP=up?0100:0010, S=0 -> MWAIT; wait counter cleared.
REQ-028 MWAIT: mem_req=1, mem_we=!load, held stable until mem_ack; counter +1/cycle; mem_ack: load->MWB, else FETCH; counter=MEM_TO without ack -> TRAP; ack same cycle as expiry wins.
REQ-029 MWB: write_reg=1, wb_s=1 -> FETCH. TRAP: trap=1, all strobes 0, held until rst.
Reset
REQ-030 rst (sampled on clk) -> state IDLE, counter 0; all outputs 0 next cycle, rst overriding any state incl. MWAIT mid-access and TRAP.
Configuration
REQ-031 Macro CPU_CTRL_LDST_EN defined: MADDR, MWAIT, MWB, TRAP and counter present per REQ-027..029.
REQ-032 Undefined: those states/counter absent; isLDST ignored (treated as data-processing -> EXEC); mem_req, mem_we, wb_s, trap tied 0.
Structure
REQ-033 Package cpu_ctrl_pkg: state enum, DP_W=11, dp field offsets, ALU_OP_ADD/SUB/MOV constants, pc_s encodings, decode patterns.
REQ-034 Sub-module mem_wait_timer (counter, clear, expire flag) under CPU_CTRL_LDST_EN; rest flat.
Verification
REQ-035 ADD ir=0xE0812003, ir_valid, cond_pass=1, ttcc=0 -> FETCH,DECODE,EXEC,WB; write_reg high 1 cycle in WB.
REQ-036 ir=0xEA000004, cond_pass=1 -> BCALC (ALU_OP=0100, alu_a_s=alu_b_s=1), BPC (write_pc, pc_s=10), FETCH.
REQ-037 ir=0xEB000010 -> BLLINK (ALU_OP=1000), BLCALC (rd_s=write_reg=1), BPC; ir=0xE12FFF1E -> BX, pc_s=01.
REQ-038 LDR ir=0xE5912004, mem_ack after 3 cycles -> mem_req 3 cycles, mem_we=0, MWB wb_s=1; STR 0xE5812004 -> mem_we=1, no writeback.
REQ-039 MEM_TO=4, mem_ack never -> TRAP after 4 MWAIT cycles, trap sticky; rst -> IDLE, trap=0; ack on 4th cycle -> no trap.
REQ-040 cond_pass=0 with ir_valid -> stays FETCH, no ld_abc; rst asserted in EXEC -> all outputs 0 next cycle.

---
 rtl/cpu_ctrl_pkg.sv | 111 +++++++++++
 rtl/cpu_ctrl_fsm_mem_wait_timer.sv | 36 +++
 rtl/cpu_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control FSM.
// - state enum (load/store states only when CPU_CTRL_LDST_EN is defined)
// - dp_ctrl layout {S, ALU_OP[3:0], SHIFT_OP[1:0], RS_IMM_S[1:0], RM_IMM_S[1:0]}
// - ALU opcodes, PC source encodings, instruction decode patterns
// - ctrl_t: the registered control word, and ctrl_decode() mapping a state to it
package cpu_ctrl_pkg;

    localparam int DP_W         = 11;
    localparam int DP_S_BIT     = 10;
    localparam int DP_ALU_LSB   = 6;
    localparam int DP_ALU_W     = 4;
    localparam int DP_SHIFT_LSB = 4;
    localparam int DP_RS_LSB    = 2;
    localparam int DP_RM_LSB    = 0;

    localparam logic [3:0] ALU_OP_ADD = 4'b0100;
    localparam logic [3:0] ALU_OP_SUB = 4'b0010;
    localparam logic [3:0] ALU_OP_MOV = 4'b1000;

    localparam logic [1:0] PC_S_PC4 = 2'b00;
    localparam logic [1:0] PC_S_B   = 2'b01;
    localparam logic [1:0] PC_S_F   = 2'b10;

    localparam logic [3:0]  OPC_B     = 4'b1010;  // ir[27:24]
    localparam logic [3:0]  OPC_BL    = 4'b1011;  // ir[27:24]
    localparam logic [23:0] BX_PAT    = 24'h12FFF1; // ir[27:4]
    localparam logic [1:0]  LDST_PAT  = 2'b01;    // ir[27:26]

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB     = 4'd4,
        S_BX     = 4'd5,
        S_BCALC  = 4'd6,
        S_BPC    = 4'd7,
        S_BLLINK = 4'd8,
        S_BLCALC = 4'd9
`ifdef CPU_CTRL_LDST_EN
        ,
        S_MADDR  = 4'd10,
        S_MWAIT  = 4'd11,
        S_MWB    = 4'd12,
        S_TRAP   = 4'd13
`endif
    } cpu_state_e;

    // fetch/dp_pass/dp_addr mark states whose outputs also depend on
    // live inputs (ir_valid, dp_ctrl_i); the top module merges those in.
    typedef struct packed {
        logic            fetch;
        logic            dp_pass;
        logic            dp_addr;
        logic            write_pc;
        logic            write_reg;
        logic [2:0]      ld_abc;
        logic            lf;
        logic [1:0]      pc_s;
        logic            alu_a_s;
        logic            alu_b_s;
        logic            rd_s;
        logic            wb_s;
        logic [DP_W-1:0] dp;
        logic            mem_req;
        logic            mem_we;
        logic            trap;
    } ctrl_t;

    function automatic logic [DP_W-1:0] dp_alu(input logic [3:0] op);
        logic [DP_W-1:0] v;
        v = '0;
        v[DP_ALU_LSB +: DP_ALU_W] = op;
        return v;
    endfunction

    function automatic ctrl_t ctrl_decode(input cpu_state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.fetch = 1'b1; c.pc_s = PC_S_PC4; end
            S_DECODE: c.ld_abc = 3'b111;
            S_EXEC:   begin c.lf = 1'b1; c.dp_pass = 1'b1; end
            S_WB:     c.write_reg = 1'b1;
            S_BX:     begin c.write_pc = 1'b1; c.pc_s = PC_S_B; end
            S_BCALC:  begin
                c.alu_a_s = 1'b1; c.alu_b_s = 1'b1; c.lf = 1'b1;
                c.dp = dp_alu(ALU_OP_ADD);
            end
            S_BPC:    begin c.write_pc = 1'b1; c.pc_s = PC_S_F; end
            S_BLLINK: begin
                c.alu_a_s = 1'b1; c.lf = 1'b1;
                c.dp = dp_alu(ALU_OP_MOV);
            end
            S_BLCALC: begin
                c.alu_a_s = 1'b1; c.alu_b_s = 1'b1; c.lf = 1'b1;
                c.dp = dp_alu(ALU_OP_ADD);
                c.rd_s = 1'b1; c.write_reg = 1'b1;
            end
`ifdef CPU_CTRL_LDST_EN
            S_MADDR:  begin c.lf = 1'b1; c.dp_addr = 1'b1; end
            S_MWAIT:  c.mem_req = 1'b1;  // mem_we filled in by the top
            S_MWB:    begin c.write_reg = 1'b1; c.wb_s = 1'b1; end
            S_TRAP:   c.trap = 1'b1;
`endif
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting for mem_ack.
// Ports: clk, rst (sync, active-high), clr (zero the count), en (count this
// cycle), expired (this is the MEM_TO-th waiting cycle).
module mem_wait_timer #(
    parameter int MEM_TO   = 16,
    parameter int MEM_TO_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [MEM_TO_W-1:0] LAST_CNT = MEM_TO_W'(MEM_TO - 1);

    logic [MEM_TO_W-1:0] count_q;
    logic [MEM_TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = count_q + MEM_TO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // Count reaches MEM_TO at the end of this cycle.
    assign expired = en && (count_q == LAST_CNT);
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control FSM for an ARM-like datapath.
// Inputs : clk, rst (sync, active-high), ir, ir_valid, dp_ctrl_i, ttcc,
//          cond_pass, mem_ack.
// Outputs: write_pc, write_ir, write_reg, ld_abc, lf, pc_s, alu_a_s, alu_b_s,
//          rd_s, wb_s, dp_ctrl, mem_req, mem_we, trap, state_dbg (state).
// Build option CPU_CTRL_LDST_EN adds the load/store states, the wait timer
// and the trap; without it load/store opcodes run as data-processing and
// mem_req, mem_we, wb_s and trap stay 0.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TO   = 16,
    parameter int MEM_TO_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     ir,
    input  logic            ir_valid,
    input  logic [DP_W-1:0] dp_ctrl_i,
    input  logic            ttcc,
    input  logic            cond_pass,
    input  logic            mem_ack,
    output logic            write_pc,
    output logic            write_ir,
    output logic            write_reg,
    output logic [2:0]      ld_abc,
    output logic            lf,
    output logic [1:0]      pc_s,
    output logic            alu_a_s,
    output logic            alu_b_s,
    output logic            rd_s,
    output logic            wb_s,
    output logic [DP_W-1:0] dp_ctrl,
    output logic            mem_req,
    output logic            mem_we,
    output logic            trap,
    output logic [3:0]      state_dbg
);
    cpu_state_e state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;

    logic is_b, is_bl, is_bx;
    assign is_b  = (ir[27:24] == OPC_B);
    assign is_bl = (ir[27:24] == OPC_BL);
    assign is_bx = (ir[27:4]  == BX_PAT);

`ifdef CPU_CTRL_LDST_EN
    logic is_ldst, wait_expired;
    logic load_q, load_d, up_q, up_d;
    assign is_ldst = (ir[27:26] == LDST_PAT);

    mem_wait_timer #(.MEM_TO(MEM_TO), .MEM_TO_W(MEM_TO_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == S_MADDR),
        .en      (state_q == S_MWAIT),
        .expired (wait_expired)
    );
`endif

    always_comb begin
        state_d = state_q;
`ifdef CPU_CTRL_LDST_EN
        load_d = load_q;
        up_d   = up_q;
`endif
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (ir_valid) begin
                if (!cond_pass)  state_d = S_FETCH;
                else if (is_b)   state_d = S_BCALC;
                else if (is_bl)  state_d = S_BLLINK;
                else             state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_bx) state_d = S_BX;
`ifdef CPU_CTRL_LDST_EN
                else if (is_ldst) begin
                    state_d = S_MADDR;
                    // ir is not guaranteed past decode, so keep L and U.
                    load_d  = ir[20];
                    up_d    = ir[23];
                end
`endif
                else state_d = S_EXEC;
            end
            S_EXEC:   state_d = ttcc ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_BX:     state_d = S_FETCH;
            S_BCALC:  state_d = S_BPC;
            S_BPC:    state_d = S_FETCH;
            S_BLLINK: state_d = S_BLCALC;
            S_BLCALC: state_d = S_BPC;
`ifdef CPU_CTRL_LDST_EN
            S_MADDR:  state_d = S_MWAIT;
            S_MWAIT:  begin
                // An ack in the expiry cycle still completes the access.
                if (mem_ack)           state_d = load_q ? S_MWB : S_FETCH;
                else if (wait_expired) state_d = S_TRAP;
            end
            S_MWB:    state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        ctrl_d = ctrl_decode(state_d);
`ifdef CPU_CTRL_LDST_EN
        if (state_d == S_MWAIT)
            ctrl_d.mem_we = ~load_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
`ifdef CPU_CTRL_LDST_EN
            load_q  <= 1'b0;
            up_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
`ifdef CPU_CTRL_LDST_EN
            load_q  <= load_d;
            up_q    <= up_d;
`endif
        end
    end

    assign state_dbg = state_q;
    assign write_pc  = ctrl_q.write_pc | (ctrl_q.fetch & ir_valid);
    assign write_ir  = ctrl_q.fetch & ir_valid;
    assign write_reg = ctrl_q.write_reg;
    assign ld_abc    = ctrl_q.ld_abc;
    assign lf        = ctrl_q.lf;
    assign pc_s      = ctrl_q.pc_s;
    assign alu_a_s   = ctrl_q.alu_a_s;
    assign alu_b_s   = ctrl_q.alu_b_s;
    assign rd_s      = ctrl_q.rd_s;
    // Only ever set by load/store states, so these are 0 in the default build.
    assign wb_s      = ctrl_q.wb_s;
    assign mem_req   = ctrl_q.mem_req;
    assign mem_we    = ctrl_q.mem_we;
    assign trap      = ctrl_q.trap;

    always_comb begin
        dp_ctrl = ctrl_q.dp;
        if (ctrl_q.dp_pass)
            dp_ctrl = dp_ctrl_i;
`ifdef CPU_CTRL_LDST_EN
        // Address calc: keep shifter/operand selects, force add/sub by U, no flags.
        if (ctrl_q.dp_addr) begin
            dp_ctrl = dp_ctrl_i;
            dp_ctrl[DP_S_BIT] = 1'b0;
            dp_ctrl[DP_ALU_LSB +: DP_ALU_W] = up_q ? ALU_OP_ADD : ALU_OP_SUB;
        end
`endif
    end

    logic unused_sink;
`ifdef CPU_CTRL_LDST_EN
    assign unused_sink = ^{ir[31:28], ir[3:0]};
`else
    assign unused_sink = ^{ir[31:28], ir[3:0], mem_ack, ctrl_q.dp_addr, MEM_TO_W'(MEM_TO)};
`endif
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
module tb_cpu_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    // Clock / reset / DUT signals
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     ir = '0;
    logic            ir_valid = 1'b0;
    logic [DP_W-1:0] dp_ctrl_i = 11'h5A5;
    logic            ttcc = 1'b0;
    logic            cond_pass = 1'b0;
    logic            mem_ack = 1'b0;
    logic            write_pc, write_ir, write_reg, lf, alu_a_s, alu_b_s, rd_s, wb_s;
    logic            mem_req, mem_we, trap;
    logic [2:0]      ld_abc;
    logic [1:0]      pc_s;
    logic [DP_W-1:0] dp_ctrl;
    logic [3:0]      state_dbg;

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.MEM_TO(4), .MEM_TO_W(8)) dut (
        .clk(clk), .rst(rst), .ir(ir), .ir_valid(ir_valid), .dp_ctrl_i(dp_ctrl_i),
        .ttcc(ttcc), .cond_pass(cond_pass), .mem_ack(mem_ack),
        .write_pc(write_pc), .write_ir(write_ir), .write_reg(write_reg),
        .ld_abc(ld_abc), .lf(lf), .pc_s(pc_s), .alu_a_s(alu_a_s), .alu_b_s(alu_b_s),
        .rd_s(rd_s), .wb_s(wb_s), .dp_ctrl(dp_ctrl), .mem_req(mem_req),
        .mem_we(mem_we), .trap(trap), .state_dbg(state_dbg)
    );

    // Expected per-cycle output snapshot
    typedef struct packed {
        logic [3:0]  st;
        logic        wpc, wir, wreg;
        logic [2:0]  abc;
        logic        lf;
        logic [1:0]  pcs;
        logic        as_, bs, rds, wbs;
        logic [10:0] dp;
        logic        mreq, mwe, trp;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           pass_cnt = 0;
    int           total_cnt = 0;

    localparam logic [31:0] I_ADD  = 32'hE0812003;
    localparam logic [31:0] I_B    = 32'hEA000004;
    localparam logic [31:0] I_BL   = 32'hEB000010;
    localparam logic [31:0] I_BX   = 32'hE12FFF1E;
    localparam logic [31:0] I_LDR  = 32'hE5912004;
    localparam logic [31:0] I_STR  = 32'hE5812004;
    localparam logic [31:0] I_LDRD = 32'hE5112004;  // load, U=0

    function automatic exp_t base(input logic [3:0] s);
        exp_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    function automatic exp_t e_fetch(input logic v);
        exp_t e;
        e = base(S_FETCH);
        e.wpc = v;
        e.wir = v;
        return e;
    endfunction

    function automatic exp_t e_dec();
        exp_t e;
        e = base(S_DECODE);
        e.abc = 3'b111;
        return e;
    endfunction

    // Driver: inputs for the coming cycle plus the outputs expected in it.
    task automatic cyc(input logic r, input logic [31:0] i, input logic v, input logic cp,
                       input logic tt, input logic ack, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        rst = r; ir = i; ir_valid = v; cond_pass = cp; ttcc = tt; mem_ack = ack;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] exp_v, got_v;
            string        nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            got_v = {state_dbg, write_pc, write_ir, write_reg, ld_abc, lf, pc_s,
                     alu_a_s, alu_b_s, rd_s, wb_s, dp_ctrl, mem_req, mem_we, trap};
            total_cnt++;
            if (got_v === exp_v)
                pass_cnt++;
            else
                $display("FAIL %s: got=%h required=%h", nm, got_v, exp_v);
        end
    end

    initial begin
        exp_t x;

        cyc(1, 0, 0, 0, 0, 0, base(S_IDLE), "rst_state");
        cyc(0, 0, 0, 0, 0, 0, base(S_IDLE), "rst_release");

        // ADD: FETCH, DECODE, EXEC, WB
        cyc(0, I_ADD, 1, 1, 0, 0, e_fetch(1), "add_fetch");
        cyc(0, I_ADD, 0, 1, 0, 0, e_dec(), "add_decode");
        x = base(S_EXEC); x.lf = 1; x.dp = 11'h5A5;
        cyc(0, I_ADD, 0, 1, 0, 0, x, "add_exec");
        x = base(S_WB); x.wreg = 1;
        cyc(0, 0, 0, 0, 0, 0, x, "add_wb");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "add_fetch_hold");

        // B
        cyc(0, I_B, 1, 1, 0, 0, e_fetch(1), "b_fetch");
        x = base(S_BCALC); x.as_ = 1; x.bs = 1; x.lf = 1; x.dp = 11'h100;
        cyc(0, 0, 0, 0, 0, 0, x, "b_calc");
        x = base(S_BPC); x.wpc = 1; x.pcs = 2'b10;
        cyc(0, 0, 0, 0, 0, 0, x, "b_pc");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "b_back");

        // BL
        cyc(0, I_BL, 1, 1, 0, 0, e_fetch(1), "bl_fetch");
        x = base(S_BLLINK); x.as_ = 1; x.lf = 1; x.dp = 11'h200;
        cyc(0, 0, 0, 0, 0, 0, x, "bl_link");
        x = base(S_BLCALC); x.as_ = 1; x.bs = 1; x.lf = 1; x.dp = 11'h100; x.rds = 1; x.wreg = 1;
        cyc(0, 0, 0, 0, 0, 0, x, "bl_calc");
        x = base(S_BPC); x.wpc = 1; x.pcs = 2'b10;
        cyc(0, 0, 0, 0, 0, 0, x, "bl_pc");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "bl_back");

        // BX
        cyc(0, I_BX, 1, 1, 0, 0, e_fetch(1), "bx_fetch");
        cyc(0, I_BX, 0, 1, 0, 0, e_dec(), "bx_decode");
        x = base(S_BX); x.wpc = 1; x.pcs = 2'b01;
        cyc(0, 0, 0, 0, 0, 0, x, "bx_pc");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "bx_back");

        // Condition fails: instruction skipped, no decode
        cyc(0, I_ADD, 1, 0, 0, 0, e_fetch(1), "cond_fail_fetch");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "cond_fail_stay");

        // Test/compare: no writeback
        cyc(0, I_ADD, 1, 1, 0, 0, e_fetch(1), "tst_fetch");
        cyc(0, I_ADD, 0, 1, 0, 0, e_dec(), "tst_decode");
        x = base(S_EXEC); x.lf = 1; x.dp = 11'h5A5;
        cyc(0, 0, 0, 0, 1, 0, x, "tst_exec");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "tst_back");

        // Reset during EXEC
        cyc(0, I_ADD, 1, 1, 0, 0, e_fetch(1), "rexec_fetch");
        cyc(0, I_ADD, 0, 1, 0, 0, e_dec(), "rexec_decode");
        x = base(S_EXEC); x.lf = 1; x.dp = 11'h5A5;
        cyc(1, 0, 0, 0, 0, 0, x, "rexec_exec");
        cyc(0, 0, 0, 0, 0, 0, base(S_IDLE), "rexec_idle");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "rexec_refetch");

`ifdef CPU_CTRL_LDST_EN
        // LDR, ack in third wait cycle
        cyc(0, I_LDR, 1, 1, 0, 0, e_fetch(1), "ldr_fetch");
        cyc(0, I_LDR, 0, 1, 0, 0, e_dec(), "ldr_decode");
        x = base(S_MADDR); x.lf = 1; x.dp = 11'h125;
        cyc(0, 0, 0, 0, 0, 0, x, "ldr_maddr");
        x = base(S_MWAIT); x.mreq = 1;
        cyc(0, 0, 0, 0, 0, 0, x, "ldr_wait1");
        cyc(0, 0, 0, 0, 0, 0, x, "ldr_wait2");
        cyc(0, 0, 0, 0, 0, 1, x, "ldr_wait3");
        x = base(S_MWB); x.wreg = 1; x.wbs = 1;
        cyc(0, 0, 0, 0, 0, 0, x, "ldr_mwb");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "ldr_back");

        // STR, immediate ack, no writeback
        cyc(0, I_STR, 1, 1, 0, 0, e_fetch(1), "str_fetch");
        cyc(0, I_STR, 0, 1, 0, 0, e_dec(), "str_decode");
        x = base(S_MADDR); x.lf = 1; x.dp = 11'h125;
        cyc(0, 0, 0, 0, 0, 0, x, "str_maddr");
        x = base(S_MWAIT); x.mreq = 1; x.mwe = 1;
        cyc(0, 0, 0, 0, 0, 1, x, "str_wait1");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "str_back");

        // Timeout -> sticky trap, cleared only by reset
        cyc(0, I_LDR, 1, 1, 0, 0, e_fetch(1), "to_fetch");
        cyc(0, I_LDR, 0, 1, 0, 0, e_dec(), "to_decode");
        x = base(S_MADDR); x.lf = 1; x.dp = 11'h125;
        cyc(0, 0, 0, 0, 0, 0, x, "to_maddr");
        x = base(S_MWAIT); x.mreq = 1;
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 0, 0, 0, 0, x, $sformatf("to_wait%0d", k + 1));
        x = base(S_TRAP); x.trp = 1;
        cyc(0, I_ADD, 1, 1, 0, 1, x, "trap_set");
        cyc(0, I_ADD, 1, 1, 0, 1, x, "trap_sticky");
        cyc(1, 0, 0, 0, 0, 0, x, "trap_rst_drive");
        cyc(0, 0, 0, 0, 0, 0, base(S_IDLE), "trap_cleared");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "trap_refetch");

        // Ack in the expiry cycle wins; U=0 selects SUB
        cyc(0, I_LDRD, 1, 1, 0, 0, e_fetch(1), "late_fetch");
        cyc(0, I_LDRD, 0, 1, 0, 0, e_dec(), "late_decode");
        x = base(S_MADDR); x.lf = 1; x.dp = 11'h0A5;
        cyc(0, 0, 0, 0, 0, 0, x, "late_maddr");
        x = base(S_MWAIT); x.mreq = 1;
        cyc(0, 0, 0, 0, 0, 0, x, "late_wait1");
        cyc(0, 0, 0, 0, 0, 0, x, "late_wait2");
        cyc(0, 0, 0, 0, 0, 0, x, "late_wait3");
        cyc(0, 0, 0, 0, 0, 1, x, "late_wait4");
        x = base(S_MWB); x.wreg = 1; x.wbs = 1;
        cyc(0, 0, 0, 0, 0, 0, x, "late_mwb");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "late_back");
`else
        // Load/store opcode runs as data-processing, no memory strobes
        cyc(0, I_LDR, 1, 1, 0, 1, e_fetch(1), "ldr_dp_fetch");
        cyc(0, I_LDR, 0, 1, 0, 1, e_dec(), "ldr_dp_decode");
        x = base(S_EXEC); x.lf = 1; x.dp = 11'h5A5;
        cyc(0, 0, 0, 0, 0, 1, x, "ldr_dp_exec");
        x = base(S_WB); x.wreg = 1;
        cyc(0, 0, 0, 0, 0, 1, x, "ldr_dp_wb");
        cyc(0, 0, 0, 0, 0, 0, e_fetch(0), "ldr_dp_back");
`endif

        // Let the monitor drain; a leftover entry is a failure
        repeat (3) @(negedge clk);
        total_cnt++;
        if (exp_q.size() == 0)
            pass_cnt++;
        else
            $display("FAIL drain: got=%0d pending required=0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
